// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM: register map, CTRL bit positions,
// counting modes and the duty comparison with its saturation rules.
package pwm_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_PSC    = 3'd1;
    localparam logic [2:0] REG_PERIOD = 3'd2;
    localparam logic [2:0] REG_DUTY   = 3'd3;
    localparam logic [2:0] REG_PCOUNT = 3'd4;
    localparam logic [2:0] REG_REMAIN = 3'd5;

    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_MODE  = 1;
    localparam int unsigned CTRL_INV   = 2;
    localparam int unsigned CTRL_BURST = 3;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    // Raw (pre-inversion) output level for a counter value, including saturation.
    function automatic logic pwm_raw_f(input logic [31:0] cnt,
                                       input logic [31:0] duty,
                                       input logic [31:0] per,
                                       input pwm_mode_e   mode);
        logic raw;
        if (duty == 32'd0) begin
            raw = 1'b0;
        end else if ((mode == PWM_EDGE) && (duty > per)) begin
            raw = 1'b1;
        end else if ((mode == PWM_CENTER) && (duty >= per)) begin
            raw = 1'b1;
        end else begin
            raw = (cnt < duty);
        end
        return raw;
    endfunction

endpackage

// File: rtl/pwm_if.sv
// Register bus between the address decoder and one PWM channel.
interface pwm_if #(
    parameter int unsigned AW = 4
);
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;

    modport master (output we, output addr, output wdata, input  rdata);
    modport slave  (input  we, input  addr, input  wdata, output rdata);
endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: prescaler, edge/center counter, shadowed PERIOD/DUTY,
// burst counter and the registered pwm/done outputs.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned PSC_W = 16,
    parameter int unsigned AW    = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    pwm_if.slave bus,
    output logic pwm_o,
    output logic done_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam logic [PSC_W-1:0] PSC_ONE = PSC_W'(1'b1);

    logic             en_q, en_d, en_prev_q;
    pwm_mode_e        mode_q, mode_d;
    logic             inv_q, inv_d, burst_q, burst_d;
    logic [PSC_W-1:0] psc_q, psc_d, psc_cnt_q, psc_cnt_d, psc_cnt_run_s;
    logic [CNT_W-1:0] per_buf_q, per_buf_d, duty_buf_q, duty_buf_d;
    logic [CNT_W-1:0] per_act_q, per_act_d, duty_act_q, duty_act_d;
    logic [CNT_W-1:0] pcount_q, pcount_d, remain_q, remain_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_run_s;
    pwm_dir_e         dir_q, dir_d, dir_run_s;
    logic             pwm_q, pwm_d, done_q, done_d;
    logic [2:0]       off_s;
    logic             start_s, run_s, per_end_s, raw_s, unused_s;

    assign off_s    = bus.addr[2:0];
    assign start_s  = en_q & ~en_prev_q;
    assign run_s    = en_q & en_prev_q;
    assign unused_s = ^{bus.addr, bus.wdata};

    // Prescaler and counter advance; wrap/turn-around found by compare so PERIOD=max is safe.
    always_comb begin
        psc_cnt_run_s = psc_cnt_q;
        cnt_run_s     = cnt_q;
        dir_run_s     = dir_q;
        per_end_s     = 1'b0;
        if (run_s) begin
            if (psc_cnt_q >= psc_q) begin
                psc_cnt_run_s = '0;
                if (mode_q == PWM_EDGE) begin
                    if (cnt_q >= per_act_q) begin
                        cnt_run_s = '0;
                        per_end_s = 1'b1;
                    end else begin
                        cnt_run_s = cnt_q + CNT_ONE;
                    end
                end else if (per_act_q == '0) begin
                    cnt_run_s = '0;
                    dir_run_s = DIR_UP;
                    per_end_s = 1'b1;
                end else if (dir_q == DIR_UP) begin
                    if (cnt_q >= (per_act_q - CNT_ONE)) begin
                        dir_run_s = DIR_DOWN;
                    end else begin
                        cnt_run_s = cnt_q + CNT_ONE;
                    end
                end else begin
                    if (cnt_q == '0) begin
                        dir_run_s = DIR_UP;
                        per_end_s = 1'b1;
                    end else begin
                        cnt_run_s = cnt_q - CNT_ONE;
                    end
                end
            end else begin
                psc_cnt_run_s = psc_cnt_q + PSC_ONE;
            end
        end else begin
            psc_cnt_run_s = psc_cnt_q;
        end
    end

    // Register writes, shadow loads and burst accounting; a CTRL write overrides burst completion.
    always_comb begin
        en_d       = en_q;
        mode_d     = mode_q;
        inv_d      = inv_q;
        burst_d    = burst_q;
        psc_d      = psc_q;
        per_buf_d  = per_buf_q;
        duty_buf_d = duty_buf_q;
        per_act_d  = per_act_q;
        duty_act_d = duty_act_q;
        pcount_d   = pcount_q;
        remain_d   = remain_q;
        done_d     = 1'b0;
        if (start_s) begin
            per_act_d  = per_buf_q;
            duty_act_d = duty_buf_q;
            if (burst_q) begin
                remain_d = pcount_q;
                if (pcount_q == '0) begin
                    en_d   = 1'b0;
                    done_d = 1'b1;
                end else begin
                    en_d = en_q;
                end
            end else begin
                remain_d = remain_q;
            end
        end else if (per_end_s) begin
            per_act_d  = per_buf_q;
            duty_act_d = duty_buf_q;
            if (burst_q && (remain_q != '0)) begin
                remain_d = remain_q - CNT_ONE;
                if (remain_q == CNT_ONE) begin
                    en_d   = 1'b0;
                    done_d = 1'b1;
                end else begin
                    en_d = en_q;
                end
            end else begin
                remain_d = remain_q;
            end
        end else begin
            remain_d = remain_q;
        end
        if (bus.we) begin
            case (off_s)
                REG_CTRL: begin
                    en_d    = bus.wdata[CTRL_EN];
                    mode_d  = pwm_mode_e'(bus.wdata[CTRL_MODE]);
                    inv_d   = bus.wdata[CTRL_INV];
                    burst_d = bus.wdata[CTRL_BURST];
                    done_d  = 1'b0;
                end
                REG_PSC:    psc_d      = bus.wdata[PSC_W-1:0];
                REG_PERIOD: per_buf_d  = bus.wdata[CNT_W-1:0];
                REG_DUTY:   duty_buf_d = bus.wdata[CNT_W-1:0];
                REG_PCOUNT: pcount_d   = bus.wdata[CNT_W-1:0];
                default:    ;
            endcase
        end else begin
            psc_d = psc_q;
        end
    end

    // A disabled channel parks its counter at 0 counting up, and its output at the idle level.
    always_comb begin
        raw_s = pwm_raw_f(32'(cnt_q), 32'(duty_act_q), 32'(per_act_q), mode_q);
        if (en_d) begin
            cnt_d     = cnt_run_s;
            psc_cnt_d = psc_cnt_run_s;
            dir_d     = dir_run_s;
        end else begin
            cnt_d     = '0;
            psc_cnt_d = '0;
            dir_d     = DIR_UP;
        end
        if (run_s) begin
            pwm_d = raw_s ^ inv_q;
        end else begin
            pwm_d = inv_q;
        end
    end

    // Read mux for this channel's registers.
    always_comb begin
        case (off_s)
            REG_CTRL:   bus.rdata = {28'd0, burst_q, inv_q, mode_q, en_q};
            REG_PSC:    bus.rdata = 32'(psc_q);
            REG_PERIOD: bus.rdata = 32'(per_buf_q);
            REG_DUTY:   bus.rdata = 32'(duty_buf_q);
            REG_PCOUNT: bus.rdata = 32'(pcount_q);
            REG_REMAIN: bus.rdata = 32'(remain_q);
            default:    bus.rdata = 32'd0;
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q       <= 1'b0;
            en_prev_q  <= 1'b0;
            mode_q     <= PWM_EDGE;
            inv_q      <= 1'b0;
            burst_q    <= 1'b0;
            psc_q      <= '0;
            psc_cnt_q  <= '0;
            per_buf_q  <= '0;
            duty_buf_q <= '0;
            per_act_q  <= '0;
            duty_act_q <= '0;
            pcount_q   <= '0;
            remain_q   <= '0;
            cnt_q      <= '0;
            dir_q      <= DIR_UP;
            pwm_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            en_q       <= en_d;
            en_prev_q  <= en_q;
            mode_q     <= mode_d;
            inv_q      <= inv_d;
            burst_q    <= burst_d;
            psc_q      <= psc_d;
            psc_cnt_q  <= psc_cnt_d;
            per_buf_q  <= per_buf_d;
            duty_buf_q <= duty_buf_d;
            per_act_q  <= per_act_d;
            duty_act_q <= duty_act_d;
            pcount_q   <= pcount_d;
            remain_q   <= remain_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            pwm_q      <= pwm_d;
            done_q     <= done_d;
        end
    end

    assign pwm_o  = pwm_q;
    assign done_o = done_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM peripheral: decodes {channel, reg} word addresses onto
// NUM_CH independent pwm_channel instances and muxes their read data.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned PSC_W  = 16,
    parameter int unsigned AW     = $clog2(NUM_CH) + 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic [NUM_CH-1:0] pwm_o,
    output logic [NUM_CH-1:0] done_o
);

    logic [AW-1:0] ch_s;
    logic [31:0]   rd_s [NUM_CH];

    assign ch_s = addr_i >> 3'd3;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_if #(.AW(AW)) ch_bus ();

        assign ch_bus.we    = we_i && (ch_s == AW'(g));
        assign ch_bus.addr  = addr_i;
        assign ch_bus.wdata = wdata_i;
        assign rd_s[g]      = ch_bus.rdata;

        pwm_channel #(
            .CNT_W (CNT_W),
            .PSC_W (PSC_W),
            .AW    (AW)
        ) u_channel (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .bus    (ch_bus.slave),
            .pwm_o  (pwm_o[g]),
            .done_o (done_o[g])
        );
    end

    // Channel select for reads; unpopulated channel slots read as zero.
    always_comb begin
        rdata_o = 32'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_s == AW'(i)) begin
                rdata_o = rd_s[i];
            end else begin
                rdata_o = rdata_o;
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: register table, directed PWM/burst/shadow/reset
// sequences, and randomized configurations compared against a waveform model.
module tb_pwm_multi;

    logic       clk;
    logic       rst_ni;
    logic [1:0] pwm_s;
    logic [1:0] done_s;
    int         n_checks;
    int         n_errors;

    pwm_if #(.AW(4)) tb_bus ();

    pwm_multi #(.NUM_CH(2), .CNT_W(16), .PSC_W(16)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .we_i    (tb_bus.we),
        .addr_i  (tb_bus.addr),
        .wdata_i (tb_bus.wdata),
        .rdata_o (tb_bus.rdata),
        .pwm_o   (pwm_s),
        .done_o  (done_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [1:0]  exp_pwm;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; the write is taken on the next rising edge.
    task automatic wr(input int a, input logic [31:0] d);
        tb_bus.we    = 1'b1;
        tb_bus.addr  = a[3:0];
        tb_bus.wdata = d;
        @(negedge clk);
        tb_bus.we    = 1'b0;
    endtask

    // Ideal raw level j clocks after the counter first holds 0.
    function automatic logic model_raw(input bit mode, input int psc, input int per,
                                       input int duty, input int j);
        int n, p, c;
        n = j / (psc + 1);
        if (!mode) begin
            c = n % (per + 1);
        end else if (per == 0) begin
            c = 0;
        end else begin
            p = n % (2 * per);
            c = (p < per) ? p : (2 * per - 1 - p);
        end
        if (duty == 0) return 1'b0;
        if (!mode && duty > per) return 1'b1;
        if (mode && duty >= per) return 1'b1;
        return (c < duty);
    endfunction

    task automatic run_cfg(input int ch, input bit mode, input int psc, input int per,
                           input int duty, input bit inv, input int ncyc, output int highs);
        int          base;
        logic [31:0] c;
        logic        expv;
        base  = ch * 8;
        c     = {29'd0, inv, mode, 1'b0};
        highs = 0;
        wr(base + 1, psc);
        wr(base + 2, per);
        wr(base + 3, duty);
        wr(base + 0, c);
        wr(base + 0, c | 32'd1);
        for (int k = 0; k < ncyc; k++) begin
            expv = (k < 2) ? inv : (model_raw(mode, psc, per, duty, k - 2) ^ inv);
            check("pwm_wave", {31'd0, pwm_s[ch]}, {31'd0, expv});
            check("pwm_other_idle", {31'd0, pwm_s[1 - ch]}, 32'd0);
            if (k >= 2 && (pwm_s[ch] ^ inv)) highs++;
            @(negedge clk);
        end
        wr(base + 0, 32'd0);
    endtask

    initial begin
        int   highs, rises, dones, done_k, waited;
        logic prev;
        logic hi [26];

        n_checks = 0;
        n_errors = 0;
        rst_ni = 1'b0;
        tb_bus.we = 1'b0;
        tb_bus.addr = 4'd0;
        tb_bus.wdata = 32'd0;

        vecs[0]  = '{4'd1,  32'hABCD_1234, 32'h0000_1234, 2'b00};
        vecs[1]  = '{4'd2,  32'h0001_0009, 32'h0000_0009, 2'b00};
        vecs[2]  = '{4'd3,  32'hFFFF_0003, 32'h0000_0003, 2'b00};
        vecs[3]  = '{4'd4,  32'h0000_0007, 32'h0000_0007, 2'b00};
        vecs[4]  = '{4'd5,  32'h0000_0055, 32'h0000_0000, 2'b00};
        vecs[5]  = '{4'd6,  32'h0000_0001, 32'h0000_0000, 2'b00};
        vecs[6]  = '{4'd7,  32'hFFFF_FFFF, 32'h0000_0000, 2'b00};
        vecs[7]  = '{4'd9,  32'h0000_0002, 32'h0000_0002, 2'b00};
        vecs[8]  = '{4'd10, 32'h0000_0008, 32'h0000_0008, 2'b00};
        vecs[9]  = '{4'd8,  32'hFFFF_FFF6, 32'h0000_0006, 2'b10};
        vecs[10] = '{4'd0,  32'h0000_0004, 32'h0000_0004, 2'b11};
        vecs[11] = '{4'd0,  32'h0000_0000, 32'h0000_0000, 2'b10};
        vecs[12] = '{4'd8,  32'h0000_0000, 32'h0000_0000, 2'b00};
        vecs[13] = '{4'd1,  32'h0000_0000, 32'h0000_0000, 2'b00};

        repeat (3) @(negedge clk);
        check("reset_pwm", {30'd0, pwm_s}, 32'd0);
        check("reset_done", {30'd0, done_s}, 32'd0);
        for (int a = 0; a < 16; a += 5) begin
            tb_bus.addr = a[3:0];
            #1;
            check("reset_rdata", tb_bus.rdata, 32'd0);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);

        // Register table: write, read back next cycle, idle output level one cycle later.
        for (int i = 0; i < 14; i++) begin
            wr(int'(vecs[i].addr), vecs[i].wdata);
            check("reg_rdata", tb_bus.rdata, vecs[i].exp_rd);
            @(negedge clk);
            check("reg_pwm_idle", {30'd0, pwm_s}, {30'd0, vecs[i].exp_pwm});
        end

        run_cfg(0, 1'b0, 0, 9, 3, 1'b0, 22, highs);
        check("edge_high_count", highs, 32'd6);
        run_cfg(1, 1'b1, 1, 8, 3, 1'b0, 66, highs);
        check("center_high_count", highs, 32'd24);
        run_cfg(0, 1'b0, 0, 9, 0, 1'b0, 25, highs);
        check("duty0_high_count", highs, 32'd0);
        run_cfg(0, 1'b0, 0, 9, 10, 1'b0, 25, highs);
        check("duty_sat_high_count", highs, 32'd23);

        wr(0, 32'd4);
        @(negedge clk);
        check("inv_disabled", {31'd0, pwm_s[0]}, 32'd1);
        wr(0, 32'd0);
        @(negedge clk);

        // DUTY rewritten mid-period takes effect only from the next period.
        wr(1, 32'd0);
        wr(2, 32'd9);
        wr(3, 32'd3);
        wr(0, 32'd1);
        for (int k = 0; k < 26; k++) begin
            hi[k] = pwm_s[0];
            if (k == 3) begin
                tb_bus.we = 1'b1;
                tb_bus.addr = 4'd3;
                tb_bus.wdata = 32'd6;
            end else if (k == 4) begin
                tb_bus.we = 1'b0;
                tb_bus.addr = 4'd0;
            end
            @(negedge clk);
        end
        highs = 0;
        for (int k = 2; k < 12; k++) highs += int'(hi[k]);
        check("shadow_cur_period", highs, 32'd3);
        highs = 0;
        for (int k = 12; k < 22; k++) highs += int'(hi[k]);
        check("shadow_next_period", highs, 32'd6);
        check("shadow_next_first", {31'd0, hi[12]}, 32'd1);
        wr(0, 32'd0);

        for (int it = 0; it < 12; it++) begin
            int rch, rpsc, rper, rduty;
            bit rmode, rinv;
            rch   = int'($urandom_range(0, 1));
            rmode = 1'($urandom_range(0, 1));
            rinv  = 1'($urandom_range(0, 1));
            rpsc  = int'($urandom_range(0, 2));
            rper  = int'($urandom_range(0, 10));
            rduty = int'($urandom_range(0, 12));
            run_cfg(rch, rmode, rpsc, rper, rduty, rinv,
                    2 + 3 * (2 * rper + 2) * (rpsc + 1), highs);
        end

        // Burst of 7 periods of 5 clocks each.
        wr(1, 32'd0);
        wr(2, 32'd4);
        wr(3, 32'd2);
        wr(4, 32'd7);
        wr(0, 32'd8);
        wr(0, 32'd9);
        rises = 0; dones = 0; done_k = -1; prev = pwm_s[0];
        for (int k = 0; k < 60; k++) begin
            if (pwm_s[0] && !prev) rises++;
            prev = pwm_s[0];
            if (done_s[0]) begin
                dones++;
                done_k = k;
                check("burst_en_at_done", {31'd0, tb_bus.rdata[0]}, 32'd0);
            end
            @(negedge clk);
        end
        check("burst_rises", rises, 32'd7);
        check("burst_dones", dones, 32'd1);
        check("burst_done_time", done_k, 32'd36);
        check("burst_idle", {31'd0, pwm_s[0]}, 32'd0);
        tb_bus.addr = 4'd5;
        #1;
        check("burst_remain", tb_bus.rdata, 32'd0);
        tb_bus.addr = 4'd0;

        wr(4, 32'd0);
        wr(0, 32'd9);
        rises = 0; dones = 0; done_k = -1; prev = pwm_s[0];
        for (int k = 0; k < 20; k++) begin
            if (pwm_s[0] && !prev) rises++;
            prev = pwm_s[0];
            if (done_s[0]) begin
                dones++;
                done_k = k;
            end
            @(negedge clk);
        end
        check("burst0_rises", rises, 32'd0);
        check("burst0_dones", dones, 32'd1);
        check("burst0_done_time", done_k, 32'd1);

        // Reset asserted while the burst output is high.
        wr(4, 32'd7);
        wr(0, 32'd9);
        waited = 0;
        while (!pwm_s[0] && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("reset_pre_high", {31'd0, pwm_s[0]}, 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_reset_pwm", {30'd0, pwm_s}, 32'd0);
        check("async_reset_done", {30'd0, done_s}, 32'd0);
        for (int a = 0; a < 16; a++) begin
            tb_bus.addr = a[3:0];
            #1;
            check("async_reset_rdata", tb_bus.rdata, 32'd0);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        tb_bus.addr = 4'd0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check("post_reset_quiet", {28'd0, pwm_s, done_s}, 32'd0);
        end
        check("post_reset_ctrl", tb_bus.rdata, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel, parametrised PWM peripheral for the Ibex user-project SoC. It replaces the single fixed-width PWM with `NUM_CH` independent channels. Each channel adds a prescaler, edge- or center-aligned counting, output inversion, shadowed period/duty registers, and a pulse-count (burst) mode with a completion pulse. It sits on the peripheral register bus, and its `pwm_o` outputs drive `mprj_io` pads through the existing GPIO mux.

## Interface
- `NUM_CH`, 2: number of channels (1–8).
- `CNT_W`, 16: width of the period, duty and counter fields (8–32).
- `PSC_W`, 16: prescaler width.
- `AW`, `$clog2(NUM_CH)+3`: register address width; derived, do not override.
- `clk_i`  in  1  single system clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `we_i`  in  1  register write strobe, one cycle per write.
- `addr_i`  in  AW  `{channel, reg[2:0]}` word address.
- `wdata_i`  in  32  write data; bits above the field width are ignored.
- `rdata_o`  out  32  combinational read of `addr_i`; zero-extended.
- `pwm_o`  out  NUM_CH  registered PWM outputs.
- `done_o`  out  NUM_CH  one-cycle pulse when a burst completes.

## Operation
- Per-channel registers:
  - 0 CTRL: bit 0 `en`, bit 1 `mode` (0 = edge, 1 = center), bit 2 `inv`, bit 3 `burst`.
  - 1 PSC.
  - 2 PERIOD (shadowed).
  - 3 DUTY (shadowed).
  - 4 PCOUNT.
  - 5 REMAIN (read-only, live burst counter).
  - Reads of offsets 6 and 7 return 0.
- Prescaler: `psc_cnt` increments every clock while `en`=1. A tick is generated when `psc_cnt==PSC`, and `psc_cnt` then returns to 0. The counter advances once per tick, so each tick lasts PSC+1 clocks.
- Edge mode: `cnt` counts 0..PERIOD, then wraps to 0. One period is PERIOD+1 ticks. Raw output is `cnt < DUTY_act`.
- Center mode: `cnt` counts up 0..PERIOD-1, then down PERIOD-1..0. Each endpoint is held for two consecutive ticks. One period is 2·PERIOD ticks. Raw output is `cnt < DUTY_act`, which gives 2·DUTY high ticks. PERIOD=0 in center mode holds `cnt`=0.
- Period end:
  - Edge mode: the tick on which `cnt` wraps to 0.
  - Center mode: the tick on which the down-count leaves 0.
- `pwm_o = raw ^ inv` while enabled. While disabled, `pwm_o = inv`, and `cnt`, `psc_cnt` and the center direction are held at 0 / up.
- Shadowing:
  - PERIOD and DUTY writes land in buffer registers.
  - The active copies load at every period end, and on the cycle `en` goes 0→1.
  - Writes of PSC, `inv` and `mode` take effect immediately. Software changes `mode` only while `en`=0.
- Saturation:
  - DUTY_act=0 gives a constant raw 0.
  - Edge mode: DUTY_act > PERIOD gives a constant raw 1.
  - Center mode: DUTY_act ≥ PERIOD gives a constant raw 1.
- Burst mode:
  - On the 0→1 edge of `en` with `burst`=1, REMAIN is loaded from PCOUNT.
  - Each period end decrements REMAIN.
  - When a decrement reaches 0, the channel clears `en` (visible in CTRL), `pwm_o` returns to `inv` on the next cycle, and `done_o` pulses for one cycle.
  - If `burst`=1 and PCOUNT=0, the channel clears `en` and pulses `done_o` on the cycle after enable, with no pulse output.
- A software write of `en`=0 mid-burst stops the channel immediately, with no `done_o`.
- A CTRL write and an internal burst-completion clear of `en` in the same cycle: the software write wins.
- Counter arithmetic is unsigned CNT_W bits. PERIOD = 2^CNT_W−1 must not overflow: wrap is detected by compare, not by carry.
- Reset values: all registers 0, `pwm_o`=0, `done_o`=0, `rdata_o` follows `addr_i`.

## Timing
- Write accepted on the clock edge where `we_i`=1. The register value is visible on `rdata_o` in the next cycle.
- Enable at edge E: `cnt`=0 is valid after E+1. The first `pwm_o` high (DUTY>0, `inv`=0) is registered at E+2.
- `pwm_o` lags the counter state by exactly one clock.
- `done_o` is asserted in the same cycle in which `en` reads back 0.
- Reset assertion is asynchronous: all outputs go to 0 immediately. Deassertion is synchronised externally.

## Structure
- `pwm_pkg`: register offsets, CTRL bit indices, `pwm_mode_e` {`PWM_EDGE`, `PWM_CENTER`}.
- Sub-module `pwm_channel`: contains the prescaler, counter, shadow registers, burst logic and output register for one channel.
- Top level `pwm_multi`: address decode, read mux, and a generate loop of `NUM_CH` instances.

## Test plan
- Ch0 edge mode, PSC=0, PERIOD=9, DUTY=3, `en`=1 → `pwm_o[0]` high 3 clocks, period 10 clocks; ch1 stays low.
- Ch1 center mode, PSC=1, PERIOD=8, DUTY=3 → period 32 clocks, high 12 clocks, symmetric about the period end.
- Burst mode, PCOUNT=7, PERIOD=4, DUTY=2 → exactly 7 rising edges, one `done_o` pulse, CTRL.`en` reads 0, REMAIN=0, output idle. Repeat with PCOUNT=0 → no edges, `done_o` on E+1.
- Edge mode PERIOD=9; write DUTY=6 while `cnt`=2 → the current period still has 3 high clocks; the next period has 6.
- DUTY=0 → constant low; DUTY=10 with PERIOD=9 → constant high; `inv`=1 with `en`=0 → `pwm_o`=1.
- Assert `rst_ni` mid-burst → `pwm_o`, `done_o` and all registers read 0 immediately. After release, with no writes → no activity.
